// File: rtl/game_mode_ctrl.sv
// Game phase sequencer: countdown, play, pause, finish and result phases,
// score-clear pulse, new-record flag and the shared two-digit BCD display mux.
module game_mode_ctrl #(
   parameter int unsigned TICK_CYCLES   = 10_000_000,
   parameter int unsigned RESULT_CYCLES = 50_000_000,
   parameter int unsigned DISP_TOGGLE   = 10_000_000
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       start,
   input  logic       pause,
   input  logic       song_done,
   input  logic [7:0] score,
   input  logic [7:0] highest_score,
   output logic [2:0] mode,
   output logic       score_clr,
   output logic [1:0] cd_digit,
   output logic       new_record,
   output logic [7:0] disp_value,
   output logic       disp_sel
);

   localparam int unsigned TICK_W = (TICK_CYCLES   > 1) ? $clog2(TICK_CYCLES)   : 1;
   localparam int unsigned RES_W  = (RESULT_CYCLES > 1) ? $clog2(RESULT_CYCLES) : 1;
   localparam int unsigned DISP_W = (DISP_TOGGLE   > 1) ? $clog2(DISP_TOGGLE)   : 1;

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
   localparam logic [RES_W-1:0]  RES_LAST  = RES_W'(RESULT_CYCLES - 1);
   localparam logic [DISP_W-1:0] DISP_LAST = DISP_W'(DISP_TOGGLE - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'b000,
      S_COUNT  = 3'b001,
      S_PLAY   = 3'b010,
      S_PAUSE  = 3'b011,
      S_FINISH = 3'b101,
      S_RESULT = 3'b110
   } state_e;

   state_e            state_q, state_d;
   logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
   logic [RES_W-1:0]  res_cnt_q, res_cnt_d;
   logic [DISP_W-1:0] disp_cnt_q, disp_cnt_d;
   logic [1:0]        cd_digit_q, cd_digit_d;
   logic              score_clr_q, score_clr_d;
   logic              new_record_q, new_record_d;
   logic              disp_sel_q, disp_sel_d;
   logic              disp_flip;

   // State, counters and registered outputs
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q      <= S_IDLE;
         tick_cnt_q   <= '0;
         res_cnt_q    <= '0;
         disp_cnt_q   <= '0;
         cd_digit_q   <= 2'd0;
         score_clr_q  <= 1'b0;
         new_record_q <= 1'b0;
         disp_sel_q   <= 1'b1;
      end else begin
         state_q      <= state_d;
         tick_cnt_q   <= tick_cnt_d;
         res_cnt_q    <= res_cnt_d;
         disp_cnt_q   <= disp_cnt_d;
         cd_digit_q   <= cd_digit_d;
         score_clr_q  <= score_clr_d;
         new_record_q <= new_record_d;
         disp_sel_q   <= disp_sel_d;
      end
   end

   // Next-state, counter advance and registered-output next values
   always_comb begin
      state_d      = state_q;
      tick_cnt_d   = tick_cnt_q;
      res_cnt_d    = res_cnt_q;
      disp_cnt_d   = disp_cnt_q;
      cd_digit_d   = cd_digit_q;
      score_clr_d  = 1'b0;
      new_record_d = new_record_q;
      disp_sel_d   = disp_sel_q;
      disp_flip    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_COUNT;
         end
         S_COUNT: begin
            if (tick_cnt_q == TICK_LAST) begin
               tick_cnt_d = '0;
               if (cd_digit_q == 2'd1) state_d = S_PLAY;
               else                    cd_digit_d = cd_digit_q - 2'd1;
            end else begin
               tick_cnt_d = tick_cnt_q + TICK_W'(1);
            end
         end
         S_PLAY: begin
            if (song_done)  state_d = S_FINISH;
            else if (pause) state_d = S_PAUSE;
         end
         S_PAUSE: begin
            // abort takes priority over resume
            if (start)      state_d = S_IDLE;
            else if (pause) state_d = S_PLAY;
         end
         S_FINISH: begin
            state_d      = S_RESULT;
            new_record_d = (score > highest_score);
         end
         S_RESULT: begin
            if (start)                       state_d = S_COUNT;
            else if (res_cnt_q == RES_LAST)  state_d = S_IDLE;
            else                             res_cnt_d = res_cnt_q + RES_W'(1);
            if (disp_cnt_q == DISP_LAST) begin
               disp_cnt_d = '0;
               disp_flip  = 1'b1;
            end else begin
               disp_cnt_d = disp_cnt_q + DISP_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // every phase change restarts all timers
      if (state_d != state_q) begin
         tick_cnt_d = '0;
         res_cnt_d  = '0;
         disp_cnt_d = '0;
      end

      // countdown digit is only meaningful inside COUNT; load 3 on entry
      if (state_d != S_COUNT)      cd_digit_d = 2'd0;
      else if (state_q != S_COUNT) cd_digit_d = 2'd3;

      score_clr_d = (state_d == S_COUNT) && (state_q != S_COUNT);

      if (state_d == S_IDLE || state_d == S_COUNT) new_record_d = 1'b0;

      // display source select for the cycle after this edge
      case (state_d)
         S_IDLE:   disp_sel_d = 1'b1;
         S_RESULT: disp_sel_d = (state_q == S_RESULT) ? (disp_sel_q ^ disp_flip) : 1'b0;
         default:  disp_sel_d = 1'b0;
      endcase
   end

   // Display mux: combinational from registered state, no added latency
   always_comb begin
      if (disp_sel_q)                 disp_value = highest_score;
      else if (state_q == S_COUNT)    disp_value = {6'b0, cd_digit_q};
      else                            disp_value = score;
   end

   assign mode       = state_q;
   assign score_clr  = score_clr_q;
   assign cd_digit   = cd_digit_q;
   assign new_record = new_record_q;
   assign disp_sel   = disp_sel_q;

endmodule
